memory_game_ctl: RTL

MEMORY_GAME_CTL -- requirements
Module: memory_game_ctl

---
 rtl/memory_game_ctl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/memory_game_ctl.sv
// Memory-match game controller: 4x4 card board clicked with a mouse.
// Tracks face-up/matched cards, move and pair counts, and the win condition.
module memory_game_ctl #(
  parameter int unsigned BOARD_X     = 144,
  parameter int unsigned BOARD_Y     = 44,
  parameter int unsigned CARD_W      = 120,
  parameter int unsigned SHOW_CYCLES = 40_000_000,
  parameter logic [63:0] CARD_MAP    = 64'h7654_3210_7654_3210
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [31:0] card_state,
  output logic [63:0] card_values,
  output logic [7:0]  moves,
  output logic [3:0]  pairs_found,
  output logic        game_won
);

  typedef enum logic [2:0] {StIdle, StOneUp, StCompare, StShow, StWon} state_e;

  state_e      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic [3:0]  idx1_q, idx2_q;
  logic [31:0] timer_q;
  logic [31:0] card_state_q;
  logic [7:0]  moves_q;
  logic [3:0]  pairs_q;
  logic        won_q;

  logic [12:0] dx, dy;
  logic        click, hit;
  logic [3:0]  hit_idx;
  logic [1:0]  hit_state;
  logic [3:0]  val1, val2;

  // Pointer decode: 13-bit difference so a cursor left of/above the board goes negative.
  always_comb begin
    dx        = {1'b0, mouse_xpos} - 13'(BOARD_X);
    dy        = {1'b0, mouse_ypos} - 13'(BOARD_Y);
    hit       = ~dx[12] & ~dy[12] & (dx[11:9] == 3'd0) & (dy[11:9] == 3'd0) &
                ({1'b0, dx[6:0]} < 8'(CARD_W)) & ({1'b0, dy[6:0]} < 8'(CARD_W));
    hit_idx   = {dy[8:7], dx[8:7]};
    hit_state = card_state_q[{hit_idx, 1'b0} +: 2];
    click     = sync2_q & ~sync3_q;
    val1      = CARD_MAP[{idx1_q, 2'b00} +: 4];
    val2      = CARD_MAP[{idx2_q, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      idx1_q       <= 4'd0;
      idx2_q       <= 4'd0;
      timer_q      <= 32'd0;
      card_state_q <= 32'd0;
      moves_q      <= 8'd0;
      pairs_q      <= 4'd0;
      won_q        <= 1'b0;
    end else begin
      sync1_q <= mouse_left;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      unique case (state_q)
        StIdle: begin
          if (click && hit && hit_state == 2'b00) begin
            card_state_q[{hit_idx, 1'b0} +: 2] <= 2'b01;
            idx1_q  <= hit_idx;
            state_q <= StOneUp;
          end
        end
        StOneUp: begin
          if (click && hit && hit_state == 2'b00 && hit_idx != idx1_q) begin
            card_state_q[{hit_idx, 1'b0} +: 2] <= 2'b01;
            idx2_q  <= hit_idx;
            if (moves_q != 8'hFF) moves_q <= moves_q + 8'd1;
            state_q <= StCompare;
          end
        end
        StCompare: begin
          if (val1 == val2) begin
            card_state_q[{idx1_q, 1'b0} +: 2] <= 2'b10;
            card_state_q[{idx2_q, 1'b0} +: 2] <= 2'b10;
            pairs_q <= pairs_q + 4'd1;
            if (pairs_q == 4'd7) begin
              won_q   <= 1'b1;
              state_q <= StWon;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            timer_q <= 32'(SHOW_CYCLES - 1);
            state_q <= StShow;
          end
        end
        StShow: begin
          if (timer_q == 32'd0) begin
            card_state_q[{idx1_q, 1'b0} +: 2] <= 2'b00;
            card_state_q[{idx2_q, 1'b0} +: 2] <= 2'b00;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        StWon: state_q <= StWon;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign card_state  = card_state_q;
  assign card_values = CARD_MAP;
  assign moves       = moves_q;
  assign pairs_found = pairs_q;
  assign game_won    = won_q;

endmodule
